// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequential binary-to-one-hot decoder.
// Provides the FSM state enum, the default code width and the one-hot
// width helper used by the decoder top and its combinational converter.
package decoder_pkg;

    // Default binary code width; the one-hot word is 2**N bits wide.
    localparam int N_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } state_e;

    // Width of the one-hot word produced from an n-bit code.
    function automatic int onehot_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/decoder3x8_seq_onehot_dec.sv
// onehot_dec: purely combinational code + enable -> one-hot converter.
// Ports: code (N-bit binary index), en (0 forces an all-zero word),
//        onehot (2**N-bit word with bit[code] set when en=1).
module onehot_dec
    import decoder_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0]           code,
    input  logic                   en,
    output logic [onehot_w(N)-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder3x8_seq.sv
// decoder3x8_seq: registered binary-to-one-hot decoder with valid/ready on both
// sides. A request is either a single decode (one beat) or a sweep (one-hot
// beats from line 0 up to and including the requested line).
// Latency: one cycle from request accept to out_valid.
// Backpressure: outputs frozen while out_valid & !out_ready; in_ready follows
// out_ready in HOLD (full-rate singles) and is low for the whole of a sweep.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; in_code, in_en, in_sweep qualify it
//   out_valid/out_ready output beat handshake
//   out_onehot          decoded word; out_code its binary index (0 if all-zero)
//   out_last            final beat of the current request
//   busy                high while a sweep is in progress
//   beat_count          (only with DECODER3X8_SEQ_COUNT_EN defined) 16-bit
//                       wrapping count of completed output beats
module decoder3x8_seq
    import decoder_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_code,
    input  logic                   in_en,
    input  logic                   in_sweep,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [onehot_w(N)-1:0] out_onehot,
    output logic [N-1:0]           out_code,
    output logic                   out_last,
    output logic                   busy
`ifdef DECODER3X8_SEQ_COUNT_EN
    ,
    output logic [15:0]            beat_count
`endif
);

    localparam int OW = onehot_w(N);

    state_e         state_q, state_d;
    logic [OW-1:0]  onehot_q, onehot_d;
    logic [N-1:0]   code_q, code_d;
    logic           last_q, last_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [N-1:0]   limit_q, limit_d;

    logic           accept;
    logic [N-1:0]   idx_nxt;
    logic [OW-1:0]  single_word;
    logic [OW-1:0]  sweep_word;

    // Values loaded on any accepted request, whichever state accepts it.
    state_e         ld_state;
    logic [OW-1:0]  ld_onehot;
    logic [N-1:0]   ld_code;
    logic           ld_last;
    logic [N-1:0]   ld_limit;

    // idx only advances while idx < limit <= 2**N-1, so this never wraps.
    assign idx_nxt = idx_q + 1'b1;

    onehot_dec #(.N(N)) u_single_dec (
        .code   (in_code),
        .en     (in_en),
        .onehot (single_word)
    );

    onehot_dec #(.N(N)) u_sweep_dec (
        .code   (idx_nxt),
        .en     (1'b1),
        .onehot (sweep_word)
    );

    // ------------------------------------------------------------------
    // Request-side handshake. HOLD passes out_ready straight through so a
    // new single can replace the beat being consumed in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    in_ready = 1'b1;
                HOLD:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Request decode: what the output registers become on an accept.
    // A disabled request is always a single all-zero beat, even if
    // in_sweep is set.
    // ------------------------------------------------------------------
    always_comb begin
        ld_state  = HOLD;
        ld_onehot = single_word;
        ld_code   = in_en ? in_code : '0;
        ld_last   = 1'b1;
        ld_limit  = limit_q;
        if (in_en && in_sweep) begin
            ld_state  = SWEEP;
            ld_onehot = {{(OW-1){1'b0}}, 1'b1};
            ld_code   = '0;
            ld_last   = (in_code == '0);
            ld_limit  = in_code;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic. Every register holds by default,
    // which is what keeps the beat stable under backpressure.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        code_d   = code_q;
        last_d   = last_q;
        idx_d    = idx_q;
        limit_d  = limit_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = ld_state;
                    onehot_d = ld_onehot;
                    code_d   = ld_code;
                    last_d   = ld_last;
                    idx_d    = '0;
                    limit_d  = ld_limit;
                end
            end

            HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d  = ld_state;
                        onehot_d = ld_onehot;
                        code_d   = ld_code;
                        last_d   = ld_last;
                        idx_d    = '0;
                        limit_d  = ld_limit;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                        code_d   = '0;
                        last_d   = 1'b0;
                    end
                end
            end

            SWEEP: begin
                if (out_ready) begin
                    if (idx_q == limit_q) begin
                        // The beat just consumed already carried out_last.
                        state_d  = IDLE;
                        onehot_d = '0;
                        code_d   = '0;
                        last_d   = 1'b0;
                        idx_d    = '0;
                    end else begin
                        idx_d    = idx_nxt;
                        onehot_d = sweep_word;
                        code_d   = idx_nxt;
                        last_d   = (idx_nxt == limit_q);
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                onehot_d = '0;
                code_d   = '0;
                last_d   = 1'b0;
                idx_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            code_q   <= '0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            limit_q  <= '0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            code_q   <= code_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            limit_q  <= limit_d;
        end
    end

    assign out_valid  = (state_q != IDLE);
    assign busy       = (state_q == SWEEP);
    assign out_onehot = onehot_q;
    assign out_code   = code_q;
    assign out_last   = last_q;

`ifdef DECODER3X8_SEQ_COUNT_EN
    logic [15:0] beat_count_q, beat_count_d;

    // Free-running 16-bit count of completed beats; wraps naturally.
    always_comb begin
        beat_count_d = beat_count_q;
        if (out_valid && out_ready) begin
            beat_count_d = beat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count_d;
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_decoder3x8_seq.sv
// Testbench for decoder3x8_seq: table-driven single decodes, hand-written
// sweep / backpressure / reset sequences and a randomized run, all checked
// against a beat-queue reference model.
module tb_decoder3x8_seq;
    import decoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_code = 3'd0;
    logic       in_en = 1'b0;
    logic       in_sweep = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_onehot;
    logic [2:0] out_code;
    logic       out_last;
    logic       busy;
`ifdef DECODER3X8_SEQ_COUNT_EN
    logic [15:0] beat_count;
`endif

    always #5 clk = ~clk;

    decoder3x8_seq #(.N(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .in_sweep   (in_sweep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .out_last   (out_last),
        .busy       (busy)
`ifdef DECODER3X8_SEQ_COUNT_EN
        ,
        .beat_count (beat_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of beats still owed downstream.
    typedef struct {
        logic [7:0] oh;
        logic [2:0] code;
        logic       last;
    } beat_t;

    beat_t mq[$];
    bit    m_sweep = 1'b0;
    int    m_beats = 0;

    typedef struct {
        logic [2:0] code;
        logic       en;
        logic [7:0] exp_oh;
        logic [2:0] exp_code;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit model_ready(input bit r, input bit ordy);
        return !r && (mq.size() == 0 || (!m_sweep && ordy));
    endfunction

    // Drive one cycle of inputs, check the DUT against the model, advance
    // the model across the clock edge, return at the following negedge.
    task automatic step(input bit r, input bit v, input logic [2:0] c,
                        input bit e, input bit s, input bit ordy);
        bit exp_rdy;
        rst = r; in_valid = v; in_code = c; in_en = e; in_sweep = s; out_ready = ordy;
        #1;
        exp_rdy = model_ready(r, ordy);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("busy", busy, mq.size() != 0 && m_sweep);
        if (mq.size() != 0) begin
            chk("out_onehot", out_onehot, mq[0].oh);
            chk("out_code", out_code, mq[0].code);
            chk("out_last", out_last, mq[0].last);
        end
`ifdef DECODER3X8_SEQ_COUNT_EN
        chk("beat_count", beat_count, m_beats & 16'hFFFF);
`endif
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_sweep = 1'b0;
            m_beats = 0;
        end else begin
            if (mq.size() != 0 && ordy) begin
                mq.delete(0);
                m_beats++;
            end
            if (v && exp_rdy) begin
                if (e && s) begin
                    for (int k = 0; k <= int'(c); k++) begin
                        mq.push_back('{oh: 8'(1 << k), code: 3'(k), last: (k == int'(c))});
                    end
                    m_sweep = 1'b1;
                end else begin
                    mq.push_back('{oh: e ? 8'(1 << c) : 8'h00, code: e ? c : 3'd0, last: 1'b1});
                    m_sweep = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int got;
        bit ordy;
        logic [7:0] sweep3 [4];

        vecs[0] = '{3'd0, 1'b1, 8'h01, 3'd0};
        vecs[1] = '{3'd1, 1'b1, 8'h02, 3'd1};
        vecs[2] = '{3'd2, 1'b1, 8'h04, 3'd2};
        vecs[3] = '{3'd3, 1'b1, 8'h08, 3'd3};
        vecs[4] = '{3'd4, 1'b1, 8'h10, 3'd4};
        vecs[5] = '{3'd5, 1'b1, 8'h20, 3'd5};
        vecs[6] = '{3'd6, 1'b1, 8'h40, 3'd6};
        vecs[7] = '{3'd7, 1'b1, 8'h80, 3'd7};
        vecs[8] = '{3'd5, 1'b0, 8'h00, 3'd0};
        sweep3[0] = 8'h01; sweep3[1] = 8'h02; sweep3[2] = 8'h04; sweep3[3] = 8'h08;

        // First reset edge brings the DUT out of X; no model checks yet.
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_onehot", out_onehot, 8'h00);
        chk("rst_out_code", out_code, 3'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Back-to-back singles from the table, including the disabled case.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, vecs[i].code, vecs[i].en, 1'b0, 1'b1);
            chk("tbl_valid", out_valid, 1'b1);
            chk("tbl_onehot", out_onehot, vecs[i].exp_oh);
            chk("tbl_code", out_code, vecs[i].exp_code);
            chk("tbl_last", out_last, 1'b1);
        end
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("tbl_drain", out_valid, 1'b0);

        // Sweep to line 3; in_valid held high to show requests are refused.
        step(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("sw3_onehot", out_onehot, sweep3[i]);
            chk("sw3_last", out_last, i == 3);
            chk("sw3_busy", busy, 1'b1);
            step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
        end
        chk("sw3_done", out_valid, 1'b0);

        // Sweep to line 0 is a single last beat.
        step(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
        chk("sw0_onehot", out_onehot, 8'h01);
        chk("sw0_last", out_last, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("sw0_idle", out_valid, 1'b0);
        chk("sw0_busy", busy, 1'b0);

        // Sweep to line 7 under alternating backpressure.
        step(1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            ordy = cyc[0];
            if (ordy) begin
                chk("bp_beat", out_onehot, 32'(1 << got));
                chk("bp_last", out_last, got == 7);
                step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
                got++;
            end else begin
                step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
                chk("bp_hold_onehot", out_onehot, 32'(1 << got));
                chk("bp_hold_code", out_code, 32'(got));
            end
        end
        chk("bp_count", got, 8);
        chk("bp_done", out_valid, 1'b0);

        // Back-to-back singles 2 then 6 in consecutive cycles.
        step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        chk("b2b_first", out_onehot, 8'h04);
        step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1);
        chk("b2b_second", out_onehot, 8'h40);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Reset during the third beat of a sweep to line 6.
        step(1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("mid_third_beat", out_onehot, 8'h04);
        step(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_onehot", out_onehot, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
        chk("post_rst_single", out_onehot, 8'h02);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        end
        chk("final_idle", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder3x8_seq.md
Name: decoder3x8_seq

Overview:
- Registered binary-to-one-hot decoder; the receive-side counterpart of the team's 8-to-3 one-hot encoder.
- Accepts an N-bit code over a valid/ready handshake and presents a 2^N-bit one-hot word with valid/ready towards downstream.
- Supports two request types:
  - single decode, one output beat;
  - sweep, one-hot beats from line 0 up to and including the requested line.
- Sits between control logic issuing line-select codes and one-hot select/enable fabrics.

Parameters:
- N, 3, input code width; output width OW = 2**N (8 by default).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge.
- in_code  in  N  binary line index.
- in_en  in  1  decode enable; 0 produces an all-zero word.
- in_sweep  in  1  1 = sweep request, 0 = single decode.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat when out_valid & out_ready.
- out_onehot  out  OW  decoded word.
- out_code  out  N  binary index of the asserted bit; 0 for an all-zero word.
- out_last  out  1  final beat of the current request.
- busy  out  1  high in SWEEP state.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; out_valid=0, out_onehot=0, out_code=0, out_last=0, busy=0.
  - in_ready is forced 0 while rst is high.
  - Reset mid-sweep abandons the sweep with no further beats.
- States: IDLE, HOLD, SWEEP. Outputs are registered; latency from accept to out_valid is 1 cycle.
- IDLE:
  - in_ready=1, out_valid=0.
  - On accept with in_en=0, or in_sweep=0: load the single word, go to HOLD.
    - Single word = 1<<in_code, or 0 if in_en=0.
    - out_code = in_code, or 0 if in_en=0.
    - out_last = 1.
  - On accept with in_en=1 and in_sweep=1: store limit=in_code, idx=0, go to SWEEP.
    - First beat: out_onehot=1, out_code=0, out_last=(in_code==0).
- HOLD:
  - out_valid=1; in_ready=out_ready, giving full throughput for back-to-back singles.
  - On out_ready with a new accept: reload per the IDLE rules in the same cycle, with no bubble.
  - On out_ready with no accept: go to IDLE.
  - On !out_ready: hold.
- SWEEP:
  - out_valid=1, in_ready=0, busy=1.
  - On out_ready:
    - if idx==limit: go to IDLE; that beat already carried out_last=1;
    - else idx+1, out_onehot=1<<(idx+1), out_last=(idx+1==limit).
- Stability: while out_valid & !out_ready, out_onehot, out_code and out_last must not change.
- Sweep length is limit+1 beats. idx never exceeds limit (at most 2**N-1), so idx never wraps.
- in_code bits are always in range; there is no illegal-input case.
- Exactly one bit of out_onehot is set, except for in_en=0 beats, which are all-zero.

Optional Feature:
- Macro: DECODER3X8_SEQ_COUNT_EN.
- When defined:
  - adds output beat_count (out, 16 bits): count of completed output beats (out_valid & out_ready);
  - reset to 0; wraps 0xFFFF -> 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package decoder_pkg:
  - state enum typedef {IDLE, HOLD, SWEEP};
  - default N constant;
  - function onehot_w(N) returning 2**N.
- One natural sub-module: onehot_dec, a purely combinational code+enable -> one-hot converter, parameterised by N. Used for both single and sweep word generation.

Test Plan:
- Reset then single requests in_code=0..7, in_en=1, out_ready=1 -> out_onehot=0x01,0x02,...,0x80 one cycle after each accept, out_last=1, out_code matches.
- in_en=0, in_code=5 -> out_onehot=0x00, out_code=0, out_last=1.
- Sweep in_code=3, out_ready=1 -> beats 0x01,0x02,0x04,0x08; out_last only on 0x08; in_ready=0 throughout; busy=1.
- Sweep in_code=0 -> single beat 0x01 with out_last=1; back to IDLE.
- Back-pressure: sweep in_code=7 with out_ready toggling 1/0 -> words held stable while stalled; all 8 beats delivered in order. Back-to-back singles 2,6 with out_ready=1 -> 0x04 then 0x40 in consecutive cycles.
- Assert rst during the third beat of a sweep with in_code=6 -> next cycle out_valid=0, out_onehot=0; a fresh single request with in_code=1 yields 0x02.
